// File: rtl/cory_fifo_pkg.sv
// Shared constants and elaboration helpers for the cory_fifo elastic buffer.
// Imported by the buffer top and its storage array.
package cory_fifo_pkg;

   localparam int CORY_FIFO_N_DEFAULT = 64;
   localparam int CORY_FIFO_D_DEFAULT = 4;

   // Smallest r with (1 << r) >= value; usable in parameter expressions.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

   function automatic bit depth_ok(input int depth);
      return (depth >= 2) && ((depth & (depth - 1)) == 0);
   endfunction

endpackage

// File: rtl/cory_fifo_mem.sv
// D x N register array: synchronous write, asynchronous read,
// asynchronous clear of every entry on reset.
module cory_fifo_mem
   import cory_fifo_pkg::*;
#(
   parameter int N = CORY_FIFO_N_DEFAULT,
   parameter int D = CORY_FIFO_D_DEFAULT,
   parameter int A = clog2(D)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         we_i,
   input  logic [A-1:0] waddr_i,
   input  logic [N-1:0] wdata_i,
   input  logic [A-1:0] raddr_i,
   output logic [N-1:0] rdata_o
);

   logic [N-1:0] mem_q [D];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < D; i++) mem_q[i] <= '0;
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cory_fifo.sv
// First-word-fall-through valid/ready elastic buffer between cory_s2p and
// cory_slave. Pointers are A+1 bits so full and empty are distinguishable.
module cory_fifo
   import cory_fifo_pkg::*;
#(
   parameter int N = CORY_FIFO_N_DEFAULT,
   parameter int D = CORY_FIFO_D_DEFAULT,
   localparam int A = clog2(D)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_a_v,
   input  logic [N-1:0] i_a_d,
   output logic         o_a_r,
   output logic         o_z_v,
   output logic [N-1:0] o_z_d,
   output logic [A:0]   o_z_s,
   input  logic         i_z_r
);

   if (!depth_ok(D)) begin : g_bad_depth
      $error("ERROR: cory_fifo depth D must be a power of 2 and at least 2");
   end

   // Handshake: a word moves when valid and ready are both high at a rising
   // edge. Ready never depends on valid in the same cycle, on either side.
   logic [A:0] wr_ptr_q, wr_ptr_d;
   logic [A:0] rd_ptr_q, rd_ptr_d;
   logic       a_r_q, a_r_d;
   logic       push, pop;
   logic       full_d;

   assign push  = i_a_v & a_r_q;
   assign pop   = o_z_v & i_z_r;

   assign o_a_r = a_r_q;
   assign o_z_v = (wr_ptr_q != rd_ptr_q);
   assign o_z_s = wr_ptr_q - rd_ptr_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      // Ready is the registered complement of the post-edge full flag, so a
      // pop from a full buffer reopens the input only on the following cycle.
      full_d = (wr_ptr_d[A-1:0] == rd_ptr_d[A-1:0]) && (wr_ptr_d[A] != rd_ptr_d[A]);
      a_r_d  = !full_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         a_r_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         a_r_q    <= a_r_d;
      end
   end

   cory_fifo_mem #(
      .N (N),
      .D (D),
      .A (A)
   ) u_mem (
      .clk     (clk),
      .reset   (reset),
      .we_i    (push),
      .waddr_i (wr_ptr_q[A-1:0]),
      .wdata_i (i_a_d),
      .raddr_i (rd_ptr_q[A-1:0]),
      .rdata_o (o_z_d)
   );

`ifndef SYNTHESIS
   // A stalled head word must not move or change until the consumer takes it.
   hold_while_stalled : assert property (
      @(posedge clk) disable iff (reset)
      (o_z_v && !i_z_r) |=> (o_z_v && $stable(o_z_d))
   ) else $error("ERROR: cory_fifo output changed while stalled");
`endif

endmodule

// File: tb/tb_cory_fifo.sv
// Self-checking bench for cory_fifo: vector table, hand-written corner
// sequences and random traffic against a queue-based reference model.
module tb_cory_fifo;

   localparam int N = 64;
   localparam int D = 4;
   localparam int A = 2;

   logic         clk = 1'b0;
   logic         reset;
   logic         i_a_v;
   logic [N-1:0] i_a_d;
   logic         o_a_r;
   logic         o_z_v;
   logic [N-1:0] o_z_d;
   logic [A:0]   o_z_s;
   logic         i_z_r;

   always #5 clk = ~clk;

   cory_fifo #(.N(N), .D(D)) dut (
      .clk   (clk),
      .reset (reset),
      .i_a_v (i_a_v),
      .i_a_d (i_a_d),
      .o_a_r (o_a_r),
      .o_z_v (o_z_v),
      .o_z_d (o_z_d),
      .o_z_s (o_z_s),
      .i_z_r (i_z_r)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: contents as a queue, plus whether an edge has passed
   // since reset (ready is low until then).
   logic [N-1:0] exp_q[$];
   bit           model_live;
   bit           last_push;

   typedef struct {
      logic         av;
      logic [N-1:0] ad;
      logic         zr;
      logic         ear;
      logic         ezv;
      logic [N-1:0] ezd;
      logic [A:0]   ezs;
   } vec_t;

   vec_t tbl[13];

   task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_check();
      logic exp_ar;
      exp_ar = model_live && (exp_q.size() != D);
      check("model_a_r", N'(o_a_r), N'(exp_ar));
      check("model_z_v", N'(o_z_v), N'(exp_q.size() != 0));
      check("model_z_s", N'(o_z_s), N'(exp_q.size()));
      if (exp_q.size() != 0) check("model_z_d", o_z_d, exp_q[0]);
   endtask

   // Evaluate the handshake from the inputs as they stand, then step the model at the edge.
   task automatic model_edge();
      bit do_push, do_pop;
      logic [N-1:0] word;
      do_push = i_a_v && model_live && (exp_q.size() < D);
      do_pop  = i_z_r && (exp_q.size() != 0);
      word    = i_a_d;
      @(posedge clk);
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(word);
      model_live = 1'b1;
      last_push  = do_push;
      #1;
   endtask

   task automatic drive(input logic av, input logic [N-1:0] ad, input logic zr);
      i_a_v = av;
      i_a_d = ad;
      i_z_r = zr;
   endtask

   task automatic cycle(input logic av, input logic [N-1:0] ad, input logic zr);
      drive(av, ad, zr);
      @(negedge clk);
      model_check();
      model_edge();
   endtask

   function automatic vec_t mk(input logic av, input logic [N-1:0] ad, input logic zr,
                               input logic ear, input logic ezv, input logic [N-1:0] ezd,
                               input logic [A:0] ezs);
      vec_t v;
      v.av = av; v.ad = ad; v.zr = zr;
      v.ear = ear; v.ezv = ezv; v.ezd = ezd; v.ezs = ezs;
      return v;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N-1:0] next_word;
      int sent;
      int budget;

      // Fill under back-pressure, full with simultaneous pop, then drain.
      tbl[0]  = mk(1'b1, 64'h11, 1'b0, 1'b0, 1'b0, 64'h0,  3'd0);
      tbl[1]  = mk(1'b1, 64'h11, 1'b0, 1'b1, 1'b0, 64'h0,  3'd0);
      tbl[2]  = mk(1'b1, 64'h22, 1'b0, 1'b1, 1'b1, 64'h11, 3'd1);
      tbl[3]  = mk(1'b1, 64'h33, 1'b0, 1'b1, 1'b1, 64'h11, 3'd2);
      tbl[4]  = mk(1'b1, 64'h44, 1'b0, 1'b1, 1'b1, 64'h11, 3'd3);
      tbl[5]  = mk(1'b1, 64'h55, 1'b0, 1'b0, 1'b1, 64'h11, 3'd4);
      tbl[6]  = mk(1'b1, 64'h55, 1'b0, 1'b0, 1'b1, 64'h11, 3'd4);
      tbl[7]  = mk(1'b1, 64'h55, 1'b1, 1'b0, 1'b1, 64'h11, 3'd4);
      tbl[8]  = mk(1'b1, 64'h55, 1'b1, 1'b1, 1'b1, 64'h22, 3'd3);
      tbl[9]  = mk(1'b0, 64'h0,  1'b1, 1'b1, 1'b1, 64'h33, 3'd3);
      tbl[10] = mk(1'b0, 64'h0,  1'b1, 1'b1, 1'b1, 64'h44, 3'd2);
      tbl[11] = mk(1'b0, 64'h0,  1'b1, 1'b1, 1'b1, 64'h55, 3'd1);
      tbl[12] = mk(1'b0, 64'h0,  1'b0, 1'b1, 1'b0, 64'h0,  3'd0);

      // Clock/reset
      drive(1'b0, '0, 1'b0);
      reset      = 1'b1;
      model_live = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_a_r", N'(o_a_r), '0);
      check("reset_z_v", N'(o_z_v), '0);
      check("reset_z_d", o_z_d, '0);
      check("reset_z_s", N'(o_z_s), '0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Table-driven vectors
      for (int i = 0; i < 13; i++) begin
         drive(tbl[i].av, tbl[i].ad, tbl[i].zr);
         @(negedge clk);
         check($sformatf("vec%0d_a_r", i), N'(o_a_r), N'(tbl[i].ear));
         check($sformatf("vec%0d_z_v", i), N'(o_z_v), N'(tbl[i].ezv));
         check($sformatf("vec%0d_z_s", i), N'(o_z_s), N'(tbl[i].ezs));
         if (tbl[i].ezv) check($sformatf("vec%0d_z_d", i), o_z_d, tbl[i].ezd);
         model_check();
         model_edge();
      end

      // Streaming: one word per cycle, occupancy pinned at 1 after the first push.
      for (int i = 0; i < 100; i++) begin
         cycle(1'b1, N'(64'h1000 + i), 1'b1);
         if (i > 0) begin
            @(negedge clk);
            check("stream_z_s", N'(o_z_s), N'(1));
            check("stream_z_d", o_z_d, N'(64'h1000 + i));
            @(posedge clk);
            #1;
         end
      end
      // The extra negedge waits above let edges pass with inputs still applied,
      // so resynchronise the model by draining with the DUT.
      drive(1'b0, '0, 1'b1);
      repeat (D + 2) @(posedge clk);
      #1;
      exp_q.delete();
      @(negedge clk);
      check("stream_drained_z_v", N'(o_z_v), '0);
      check("stream_drained_a_r", N'(o_a_r), N'(1));
      @(posedge clk);
      #1;

      // Pointer wrap: 13 words with random valid/ready.
      next_word = 64'hA000;
      sent      = 0;
      budget    = 0;
      while ((sent < 3 * D + 1 || exp_q.size() != 0) && budget < 500) begin
         cycle((sent < 3 * D + 1) ? 1'($urandom_range(0, 1)) : 1'b0, next_word,
               1'($urandom_range(0, 1)));
         if (last_push) begin
            sent++;
            next_word = next_word + 1;
         end
         budget++;
      end
      check("wrap_all_words_sent", N'(sent), N'(3 * D + 1));
      check("wrap_drained", N'(exp_q.size()), '0);

      // Longer random traffic with random data.
      for (int i = 0; i < 300; i++) begin
         cycle(1'($urandom_range(0, 3) != 0), {$urandom, $urandom}, 1'($urandom_range(0, 2) != 0));
      end

      // Reset mid-operation with three words held.
      budget = 0;
      while (exp_q.size() != 0 && budget < 20) begin
         cycle(1'b0, '0, 1'b1);
         budget++;
      end
      for (int i = 0; i < 3; i++) cycle(1'b1, N'(64'hC0 + i), 1'b0);
      @(negedge clk);
      check("pre_reset_z_s", N'(o_z_s), N'(3));
      #2;
      reset = 1'b1;
      #1;
      check("async_reset_z_v", N'(o_z_v), '0);
      check("async_reset_z_s", N'(o_z_s), '0);
      check("async_reset_a_r", N'(o_a_r), '0);
      check("async_reset_z_d", o_z_d, '0);
      exp_q.delete();
      model_live = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      cycle(1'b1, 64'hAA, 1'b0);
      cycle(1'b1, 64'hAA, 1'b0);
      drive(1'b0, '0, 1'b0);
      @(negedge clk);
      check("post_reset_head", o_z_d, 64'hAA);
      check("post_reset_z_s", N'(o_z_s), N'(1));
      model_check();
      model_edge();
      cycle(1'b0, '0, 1'b1);
      cycle(1'b0, '0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
